fb_mem_arbiter: RTL and testbench

- Shares one single-port, synchronous-read 8-bit framebuffer RAM between two requesters: the VGA pixel fetch path (read-only, real-time) and the CPU/image-processing core (read/write).
- Sits between the VGA controller's pixel-address/pixel-data interface and the framebuffer RAM, running on the system clock, which is faster than the divided pixel clock.
- VGA has priority by default. A starvation counter guarantees the CPU forward progress.

---
 rtl/fb_mem_arbiter_if.sv | 40 ++++
 rtl/fb_mem_arbiter.sv | 115 +++++++++++
 tb/tb_fb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fb_mem_arbiter_if.sv
// rtl/fb_mem_arbiter_if.sv - VGA, CPU and RAM signal bundle for the framebuffer arbiter
interface fb_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8,
  parameter int MISS_W = 16
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;
  logic              vga_miss;
  logic [MISS_W-1:0] miss_count;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vga_data, vga_valid, vga_miss, miss_count,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vga_data, vga_valid, vga_miss, miss_count,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/fb_mem_arbiter.sv
// rtl/fb_mem_arbiter.sv - single-port framebuffer RAM arbiter, VGA priority with CPU starvation guard
module fb_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4,
  parameter int MISS_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  fb_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_VGA,
    TAG_CPU_RD,
    TAG_CPU_WR
  } tag_t;

  localparam logic [7:0]        LIMIT     = 8'(STARVE_LIMIT);
  localparam logic [MISS_W-1:0] MISS_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [DATA_W-1:0] DATA_ZERO = '0;

  logic              force_cpu;
  logic              vga_win;
  logic              cpu_win;
  logic              vga_drop;
  logic [ADDR_W-1:0] issue_addr;
  logic [7:0]        starve;

  // A dropped VGA request rides alongside the CPU op that displaced it,
  // so it gets its own flag rather than sharing the winner's tag.
  tag_t tag1, tag2;
  logic drop1, drop2;

  always_comb begin
    force_cpu  = bus.cpu_req & (starve == LIMIT);
    vga_win    = bus.vga_req & ~force_cpu;
    cpu_win    = bus.cpu_req & (~bus.vga_req | force_cpu);
    vga_drop   = bus.vga_req & force_cpu;
    issue_addr = vga_win ? bus.vga_addr : bus.cpu_addr;
  end

  assign bus.cpu_gnt = cpu_win & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_addr  <= ADDR_ZERO;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= DATA_ZERO;
      tag1          <= TAG_NONE;
      drop1         <= 1'b0;
    end else begin
      drop1 <= vga_drop;
      if (vga_win) begin
        bus.mem_addr <= issue_addr;
        bus.mem_we   <= 1'b0;
        tag1         <= TAG_VGA;
      end else if (cpu_win) begin
        bus.mem_addr <= issue_addr;
        bus.mem_we   <= bus.cpu_we;
        if (bus.cpu_we) begin
          bus.mem_wdata <= bus.cpu_wdata;
        end
        tag1 <= bus.cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
      end else begin
        bus.mem_we <= 1'b0;
        tag1       <= TAG_NONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= 8'd0;
    end else if (bus.cpu_req && !cpu_win) begin
      if (starve != LIMIT) begin
        starve <= starve + 8'd1;
      end
    end else begin
      starve <= 8'd0;
    end
  end

  // Stage 2 lines up with RAM read data, one edge after the address was registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag2           <= TAG_NONE;
      drop2          <= 1'b0;
      bus.vga_data   <= DATA_ZERO;
      bus.vga_valid  <= 1'b0;
      bus.vga_miss   <= 1'b0;
      bus.miss_count <= '0;
      bus.cpu_rdata  <= DATA_ZERO;
      bus.cpu_rvalid <= 1'b0;
    end else begin
      tag2           <= tag1;
      drop2          <= drop1;
      bus.vga_valid  <= (tag2 == TAG_VGA);
      bus.cpu_rvalid <= (tag2 == TAG_CPU_RD);
      bus.vga_miss   <= drop2;
      if (tag2 == TAG_VGA) begin
        bus.vga_data <= bus.mem_rdata;
      end
      if (tag2 == TAG_CPU_RD) begin
        bus.cpu_rdata <= bus.mem_rdata;
      end
      if (drop2 && (bus.miss_count != MISS_MAX)) begin
        bus.miss_count <= bus.miss_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb/tb_fb_mem_arbiter.sv - self-checking bench for fb_mem_arbiter against a transaction-level model
module tb_fb_mem_arbiter;
  localparam int LIMIT = 4;
  localparam int NEV   = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fb_mem_arbiter_if #(.ADDR_W(32), .DATA_W(8), .MISS_W(16)) bus ();
  fb_mem_arbiter_if #(.ADDR_W(32), .DATA_W(8), .MISS_W(2))  bus2 ();

  fb_mem_arbiter #(.ADDR_W(32), .DATA_W(8), .STARVE_LIMIT(LIMIT), .MISS_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  fb_mem_arbiter #(.ADDR_W(32), .DATA_W(8), .STARVE_LIMIT(LIMIT), .MISS_W(2)) u_sat (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  assign bus2.vga_req   = bus.vga_req;
  assign bus2.vga_addr  = bus.vga_addr;
  assign bus2.cpu_req   = bus.cpu_req;
  assign bus2.cpu_we    = bus.cpu_we;
  assign bus2.cpu_addr  = bus.cpu_addr;
  assign bus2.cpu_wdata = bus.cpu_wdata;
  assign bus2.mem_rdata = bus.mem_rdata;

  // Synchronous-read RAM with write-before-read on the same address
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_we) begin
      ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      bus.mem_rdata          <= bus.mem_wdata;
    end else begin
      bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end
  end

  int errors = 0;
  int checks = 0;

  logic [7:0]  shadow [256];
  int          denied;
  int          miss;
  logic [7:0]  vdata_m, crdata_m, wdata_m;
  logic [31:0] maddr_m;
  logic        mwe_m;
  int          edge_n;
  logic        ev_vv [NEV];
  logic        ev_vm [NEV];
  logic        ev_cr [NEV];
  logic [7:0]  ev_vd [NEV];
  logic [7:0]  ev_cd [NEV];
  logic        pend, pend_we;
  logic [31:0] pend_addr;
  logic [7:0]  pend_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NEV; i++) begin
      ev_vv[i] = 1'b0; ev_vm[i] = 1'b0; ev_cr[i] = 1'b0;
      ev_vd[i] = 8'h00; ev_cd[i] = 8'h00;
    end
    denied = 0; miss = 0;
    vdata_m = 8'h00; crdata_m = 8'h00; wdata_m = 8'h00;
    maddr_m = 32'h0; mwe_m = 1'b0; pend = 1'b0;
  endtask

  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [7:0] wd);
    pend = 1'b1; pend_we = we; pend_addr = addr; pend_wd = wd;
  endtask

  // One clock: predict arbitration from the rules, then check every output after the edge.
  task automatic step(input logic vreq, input logic [31:0] vaddr);
    logic force_c, vwin, cwin;
    int   e;
    bus.vga_req   = vreq;
    bus.vga_addr  = vaddr;
    bus.cpu_req   = pend;
    bus.cpu_we    = pend_we;
    bus.cpu_addr  = pend_addr;
    bus.cpu_wdata = pend_wd;
    #1;
    force_c = pend && (denied == LIMIT);
    vwin    = vreq && !force_c;
    cwin    = pend && (!vreq || force_c);
    chk("cpu_gnt", bus.cpu_gnt, cwin);
    e = edge_n + 1;
    if (vwin) begin
      ev_vv[e+2] = 1'b1;
      ev_vd[e+2] = shadow[vaddr[7:0]];
      maddr_m    = vaddr;
      mwe_m      = 1'b0;
    end else if (cwin) begin
      maddr_m = pend_addr;
      mwe_m   = pend_we;
      if (pend_we) begin
        shadow[pend_addr[7:0]] = pend_wd;
        wdata_m = pend_wd;
      end else begin
        ev_cr[e+2] = 1'b1;
        ev_cd[e+2] = shadow[pend_addr[7:0]];
      end
    end else begin
      mwe_m = 1'b0;
    end
    if (vreq && force_c) ev_vm[e+2] = 1'b1;
    if (pend && !cwin) denied = (denied < LIMIT) ? denied + 1 : LIMIT;
    else denied = 0;
    if (cwin) pend = 1'b0;

    @(posedge clk);
    edge_n = e;
    #1;
    if (ev_vv[e]) vdata_m = ev_vd[e];
    if (ev_cr[e]) crdata_m = ev_cd[e];
    if (ev_vm[e] && miss < 65535) miss++;
    chk("vga_valid",  bus.vga_valid,  ev_vv[e]);
    chk("vga_miss",   bus.vga_miss,   ev_vm[e]);
    chk("vga_data",   bus.vga_data,   vdata_m);
    chk("cpu_rvalid", bus.cpu_rvalid, ev_cr[e]);
    chk("cpu_rdata",  bus.cpu_rdata,  crdata_m);
    chk("miss_count", bus.miss_count, miss);
    chk("miss_sat",   bus2.miss_count, (miss > 3) ? 3 : miss);
    chk("mem_addr",   bus.mem_addr,   maddr_m);
    chk("mem_we",     bus.mem_we,     mwe_m);
    chk("mem_wdata",  bus.mem_wdata,  wdata_m);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.vga_req = 1'b0;
    bus.cpu_req = 1'b1;
    #1;
    chk("rst_vga_data",   bus.vga_data,   0);
    chk("rst_vga_valid",  bus.vga_valid,  0);
    chk("rst_vga_miss",   bus.vga_miss,   0);
    chk("rst_miss_count", bus.miss_count, 0);
    chk("rst_cpu_rdata",  bus.cpu_rdata,  0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_mem_addr",   bus.mem_addr,   0);
    chk("rst_mem_we",     bus.mem_we,     0);
    chk("rst_mem_wdata",  bus.mem_wdata,  0);
    chk("rst_cpu_gnt",    bus.cpu_gnt,    0);
    repeat (2) @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    rst = 1'b0;
    clear_model();
  endtask

  initial begin
    bus.vga_req = 1'b0; bus.vga_addr = 32'h0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 8'h00;
    pend_we = 1'b0; pend_addr = 32'h0; pend_wd = 8'h00;
    edge_n = 0;
    clear_model();
    #2;
    do_reset();

    // Fill the addresses the random phase will touch, plus the directed ones
    for (int i = 0; i < 16; i++) begin
      cpu_op(1'b1, 32'(i), 8'($urandom));
      step(1'b0, 32'h0);
    end
    cpu_op(1'b1, 32'h10, 8'h5A); step(1'b0, 32'h0);
    cpu_op(1'b1, 32'h20, 8'hA5); step(1'b0, 32'h0);

    // VGA read of 0xA5 at 0x20
    step(1'b1, 32'h20);
    chk("vga_rd_addr", bus.mem_addr, 32'h20);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    chk("vga_rd_data", bus.vga_data, 8'hA5);
    step(1'b0, 32'h0);
    chk("vga_rd_hold", bus.vga_data, 8'hA5);

    // Reset while a VGA read is in flight
    step(1'b1, 32'h10);
    bus.vga_req = 1'b0;
    @(posedge clk);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
    chk("rst_inflight_data", bus.vga_data, 8'h00);

    // CPU write then read of the same address
    cpu_op(1'b1, 32'h40, 8'h3C);
    step(1'b0, 32'h0);
    cpu_op(1'b0, 32'h40, 8'h00);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    chk("wr_rd_data", bus.cpu_rdata, 8'h3C);

    // Alternating VGA with CPU held: CPU always finds a free slot
    for (int i = 0; i < 16; i++) begin
      if (!pend) cpu_op(1'b0, 32'($urandom_range(0, 15)), 8'h00);
      step((i % 2) == 0, 32'($urandom_range(0, 15)));
    end
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    chk("alt_no_miss", bus.miss_count, 0);

    // Continuous VGA: CPU forced in on the fifth cycle, one miss
    cpu_op(1'b0, 32'h3, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b1, 32'($urandom_range(0, 15)));
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    chk("starve_miss1", bus.miss_count, 1);

    // Five more drops saturate the 2-bit counter
    for (int j = 0; j < 5; j++) begin
      cpu_op(1'b1, 32'($urandom_range(0, 15)), 8'($urandom));
      for (int i = 0; i < 5; i++) step(1'b1, 32'($urandom_range(0, 15)));
    end
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    chk("miss_wide", bus.miss_count, 6);
    chk("miss_saturated", bus2.miss_count, 3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (!pend && ($urandom_range(0, 99) < 60))
        cpu_op(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), 8'($urandom));
      step($urandom_range(0, 99) < 70, 32'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
